mul_cpa_pipe: RTL and testbench
===============================

Name: mul_cpa_pipe

Overview:
- Final carry-propagate stage of the 32x32 Wallace multiplier: consumes the redundant sum/carry vector pair from the last CSA level and produces the binary product.
- Two-stage pipelined split adder (low half, then high half) with valid/ready handshake and reservation-station tag passthrough.
- Output feeds the common data bus (CDB) arbiter; supports a squash on branch mispredict.

Parameters:
- WIDTH, 64, width of sum/carry/product vectors; must be even.
- HALF, WIDTH/2, split point between stage-1 and stage-2 adders.
- TAG_W, 4, reservation-station/ROB tag width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  squash all in-flight entries (mispredict).
- in_valid  input  1  sum/carry pair valid from CSA tree.
- in_ready  output  1  stage can accept this cycle.
- in_sum  input  WIDTH  redundant sum vector.
- in_carry  input  WIDTH  redundant carry vector, already left-aligned (bit 0 = 0).
- in_tag  input  TAG_W  issuing reservation-station tag.
- out_valid  output  1  product valid for CDB.
- out_ready  input  1  CDB grant; transfer when out_valid && out_ready.
- out_product  output  WIDTH  (in_sum + in_carry) mod 2^WIDTH.
- out_tag  output  TAG_W  tag travelling with product.

Behaviour:
- Reset (rst_n=0 at edge): s1_valid=0, s2_valid=0, out_valid=0, out_product=0, out_tag=0, all pipeline data regs 0. in_ready=1 combinationally once s1 empty (in_ready is 1 during reset cycle is don't-care; accepts nothing while rst_n=0).
- Stage 1 (on accept): s1_lo = in_sum[HALF-1:0] + in_carry[HALF-1:0] (HALF bits), s1_c = carry-out of that add; s1_sum_hi/s1_carry_hi = upper halves registered raw; s1_tag = in_tag.
- Stage 2 (on advance): out_product[HALF-1:0] = s1_lo; out_product[WIDTH-1:HALF] = s1_sum_hi + s1_carry_hi + s1_c, carry-out discarded (modular).
- Handshake: s2_free = !s2_valid || out_ready; s1_adv = s1_valid && s2_free; in_ready = !s1_valid || s2_free. Accept = in_valid && in_ready.
- Latency: accept at edge N -> out_valid high after edge N+1; throughput 1/cycle with out_ready=1.
- Stall: out_valid && !out_ready holds out_product/out_tag stable; s1 fills, then in_ready=0. No data dropped, no duplicate transfer.
- Simultaneous: output transfer and s1 advance in same cycle allowed (full pipe still streams); accept and s1 advance same cycle allowed.
- flush: at edge, s1_valid<=0, s2_valid<=0 regardless of handshake; in_valid in flush cycle is not accepted (flush dominates). Data regs may keep stale values.
- rst_n takes priority over flush; reset mid-stall drops both entries.
- out_valid is register-driven (no combinational path from in_* to out_*); only in_ready depends combinationally on out_ready.

Decomposition:
- Shared package/header: WIDTH, HALF, TAG_W defaults and tag type width, reused by CSA tree and CDB arbiter.
- One natural sub-module: cpa_half_adder_reg (HALF-bit adder with carry-in/carry-out), instantiated twice (stage-1 low half with cin=0, stage-2 high half with cin=s1_c).

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, out_product=0, out_tag=0; no acceptance.
- Single op: sum=0x0000_0000_FFFF_FFFF, carry=0x0000_0000_0000_0002, tag=5, out_ready=1 -> two edges later out_valid=1, product=0x0000_0001_0000_0001, tag=5 (cross-half carry).
- Wrap: sum=0xFFFF_FFFF_FFFF_FFFE, carry=0x0000_0000_0000_0004 -> product=0x0000_0000_0000_0002 (modular).
- Backpressure: stream tags 1..4 with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, out holds tag 1 stable; release -> tags 1,2,3,4 emitted in order, each exactly once.
- Flush: two ops in flight, assert flush one cycle with in_valid=1 (tag 7) -> next cycle out_valid=0, tag 7 never emitted; subsequent op tag 8 emerges normally.
- Random: 10k random sum/carry pairs with random out_ready -> every product equals (sum+carry) mod 2^64, tag order preserved.

Source files
------------

// File: rtl/mul_cpa_pipe_pkg.sv
// Shared sizing for the multiplier back end: CSA tree, final CPA and CDB arbiter
// all agree on vector width, split point and reservation-station tag width.
package mul_cpa_pipe_pkg;

  localparam int CPA_WIDTH = 64;
  localparam int CPA_HALF  = CPA_WIDTH / 2;
  localparam int CPA_TAG_W = 4;

  typedef logic [CPA_TAG_W-1:0] cpa_tag_t;
  typedef logic [CPA_WIDTH-1:0] cpa_vec_t;

endpackage

// File: rtl/cpa_half_adder_reg.sv
// Registered HALF-bit adder with carry-in and registered carry-out; one
// instance per pipeline stage of the split carry-propagate adder.
module cpa_half_adder_reg
  import mul_cpa_pipe_pkg::*;
#(
  parameter int HALF = CPA_HALF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [HALF-1:0] a_i,
  input  logic [HALF-1:0] b_i,
  input  logic            cin_i,
  output logic [HALF-1:0] sum_o,
  output logic            cout_o
);

  logic [HALF:0]   add_d;
  logic [HALF-1:0] sum_q;
  logic            cout_q;

  assign add_d = {1'b0, a_i} + {1'b0, b_i} + {{HALF{1'b0}}, cin_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en_i) begin
      {cout_q, sum_q} <= add_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/mul_cpa_pipe.sv
// Final carry-propagate stage of the Wallace multiplier: low half added in
// stage 1, high half plus the low-half carry in stage 2, valid/ready both ends.
module mul_cpa_pipe
  import mul_cpa_pipe_pkg::*;
#(
  parameter int WIDTH = CPA_WIDTH,
  parameter int HALF  = WIDTH / 2,
  parameter int TAG_W = CPA_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product,
  output logic [TAG_W-1:0] out_tag
);

  logic             s2_free;
  logic             s1_adv;
  logic             accept;

  logic             s1_valid_q, s1_valid_d;
  logic [HALF-1:0]  s1_lo;
  logic             s1_c;
  logic [HALF-1:0]  s1_sum_hi_q;
  logic [HALF-1:0]  s1_carry_hi_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             out_valid_q, out_valid_d;
  logic [HALF-1:0]  out_lo_q;
  logic [HALF-1:0]  out_hi;
  logic [TAG_W-1:0] out_tag_q;
  logic             s2_cout_unused;

  // Flush dominates: nothing presented in a squash cycle enters the pipe.
  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush)       s1_valid_d = 1'b0;
    else if (accept) s1_valid_d = 1'b1;
    else if (s1_adv) s1_valid_d = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (s1_adv)    out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---- stage 1: low-half add, upper halves carried raw ----
  cpa_half_adder_reg #(.HALF(HALF)) u_lo_add (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (accept),
    .a_i    (in_sum[HALF-1:0]),
    .b_i    (in_carry[HALF-1:0]),
    .cin_i  (1'b0),
    .sum_o  (s1_lo),
    .cout_o (s1_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s1_tag_q      <= '0;
    end else if (accept) begin
      s1_sum_hi_q   <= in_sum[WIDTH-1:HALF];
      s1_carry_hi_q <= in_carry[WIDTH-1:HALF];
      s1_tag_q      <= in_tag;
    end
  end

  // ---- stage 2: high-half add with stage-1 carry, result modulo 2^WIDTH ----
  cpa_half_adder_reg #(.HALF(HALF)) u_hi_add (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (s1_adv),
    .a_i    (s1_sum_hi_q),
    .b_i    (s1_carry_hi_q),
    .cin_i  (s1_c),
    .sum_o  (out_hi),
    .cout_o (s2_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_lo_q  <= '0;
      out_tag_q <= '0;
    end else if (s1_adv) begin
      out_lo_q  <= s1_lo;
      out_tag_q <= s1_tag_q;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = {out_hi, out_lo_q};
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_mul_cpa_pipe.sv
// Scoreboard bench for mul_cpa_pipe: expected products queued at acceptance,
// compared in order at each output transfer.
module tb_mul_cpa_pipe;
  import mul_cpa_pipe_pkg::*;

  localparam int WIDTH = 64;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [WIDTH-1:0] in_carry = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_product;
  logic [TAG_W-1:0] out_tag;

  typedef struct packed {
    logic [WIDTH-1:0] prod;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_emitted = 0;

  always #5 clk = ~clk;

  mul_cpa_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sum      (in_sum),
    .in_carry    (in_carry),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor/scoreboard: inputs are stable at negedge, so what is seen here
  // is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      check_eq("sb_has_entry", {63'd0, sb_q.size() != 0}, 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("sb_product", out_product, e.prod);
        check_eq("sb_tag", {60'd0, out_tag}, {60'd0, e.tag});
      end
      n_emitted++;
    end
    if (!rst_n || flush) sb_q.delete();
    if (rst_n && !flush && in_valid && in_ready) begin
      e.prod = in_sum + in_carry;
      e.tag  = in_tag;
      sb_q.push_back(e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t);
    int k;
    k = 0;
    in_sum = s; in_carry = c; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check_eq("send_timeout", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && k < 200) begin
      step();
      k++;
    end
    check_eq("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int nacc;
    int base;
    int cyc;
    logic acc;

    // Reset held with a pending request
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_sum = 64'h1234; in_carry = 64'h10; in_tag = 4'd9;
    step(); step();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_product", out_product, 64'd0);
    check_eq("rst_out_tag", {60'd0, out_tag}, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_no_accept", {63'd0, out_valid}, 64'd0);
    end

    // Single op with carry crossing the split point
    base = n_emitted;
    send(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0002, 4'd5);
    check_eq("single_lat1_valid", {63'd0, out_valid}, 64'd0);
    step();
    check_eq("single_valid", {63'd0, out_valid}, 64'd1);
    check_eq("single_product", out_product, 64'h0000_0001_0000_0001);
    check_eq("single_tag", {60'd0, out_tag}, 64'd5);
    drain();

    // Modular wrap
    send(64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0004, 4'd6);
    step();
    check_eq("wrap_valid", {63'd0, out_valid}, 64'd1);
    check_eq("wrap_product", out_product, 64'h0000_0000_0000_0002);
    drain();
    check_eq("single_wrap_count", 64'(n_emitted - base), 64'd2);

    // Backpressure: tags 1..4 streamed into a stalled output
    base = n_emitted;
    out_ready = 1'b0;
    nacc = 0;
    in_valid = 1'b1; in_sum = 64'h0000_0001_8000_0000; in_carry = 64'h0000_0000_8000_0000; in_tag = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        nacc++;
        in_tag = 4'(nacc + 1);
        in_sum = in_sum + 64'h1_0000_0003;
        in_carry = {in_carry[62:0], 1'b0};
      end
      if (i >= 2) check_eq("bp_out_tag_hold", {60'd0, out_tag}, 64'd1);
    end
    check_eq("bp_accepts", 64'(nacc), 64'd2);
    check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check_eq("bp_out_valid", {63'd0, out_valid}, 64'd1);
    check_eq("bp_out_product", out_product, 64'h0000_0002_0000_0000);
    out_ready = 1'b1;
    cyc = 0;
    while (nacc < 4 && cyc < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        nacc++;
        in_tag = 4'(nacc + 1);
        in_sum = in_sum + 64'h1_0000_0003;
        in_carry = {in_carry[62:0], 1'b0};
      end
      cyc++;
    end
    in_valid = 1'b0;
    drain();
    check_eq("bp_emitted", 64'(n_emitted - base), 64'd4);

    // Flush with two in flight and a competing request
    base = n_emitted;
    out_ready = 1'b0;
    send(64'h1111, 64'h2222, 4'd11);
    send(64'h3333, 64'h4444, 4'd12);
    check_eq("flush_pre_valid", {63'd0, out_valid}, 64'd1);
    flush = 1'b1; in_valid = 1'b1; in_sum = 64'h7777; in_carry = 64'h0; in_tag = 4'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("flush_no_tag7", {63'd0, out_valid}, 64'd0);
    end
    send(64'h0000_0008_0000_0000, 64'h0000_0000_0000_0008, 4'd8);
    step();
    check_eq("flush_tag8", {60'd0, out_tag}, 64'd8);
    drain();
    check_eq("flush_emitted", 64'(n_emitted - base), 64'd1);

    // Reset while stalled drops both entries
    out_ready = 1'b0;
    send(64'hAAAA, 64'h2, 4'd3);
    send(64'hBBBB, 64'h4, 4'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("rst_stall_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    step(); step();
    check_eq("rst_stall_empty", {63'd0, out_valid}, 64'd0);

    // Random traffic with random backpressure
    base = n_emitted;
    nacc = 0; cyc = 0;
    in_valid = 1'b0;
    while (nacc < 10000 && cyc < 60000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       begin in_sum = '1; in_carry = '1 << 1; end
          1:       begin in_sum = {32'd0, 32'hFFFF_FFFF}; in_carry = {$urandom, 31'd0, 1'b0}; end
          default: begin in_sum = {$urandom, $urandom}; in_carry = {$urandom, $urandom} & ~64'd1; end
        endcase
        in_tag = 4'(nacc);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) nacc++;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("rand_accepted", 64'(nacc), 64'd10000);
    drain();
    check_eq("rand_emitted", 64'(n_emitted - base), 64'd10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
